cnn_input_pooler: RTL
=====================

CNN_INPUT_POOLER -- requirements
Module: cnn_input_pooler

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, meaning pixels per camera line.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, meaning lines per frame.
REQ-003 SHALL have parameter REC_WIDTH, default 8, meaning pooling block width (power of two).
REQ-004 SHALL have parameter REC_HEIGHT, default 8, meaning pooling block height (power of two).
REQ-005 SHALL have parameter CNN_INPUT_WIDTH, default 28, meaning pooled cells per row.
REQ-006 SHALL have parameter CNN_INPUT_HEIGHT, default 28, meaning pooled rows.
REQ-007 SHALL have parameter CNN_INPUT_PAD, default 2, meaning border cells on each side.
REQ-008 SHALL have parameter CAM_D_SIZE, default 8, meaning pixel and output data width.
REQ-009 SHALL have parameter THRESHOLD, default 'b01100000000000, meaning binary-mode block-sum threshold.
REQ-010 SHALL have parameter PAD_VALUE, default 0, meaning data written to border cells.
REQ-011 Derived: OUT_W = CNN_INPUT_WIDTH+2*CNN_INPUT_PAD, OUT_H likewise, ACC_D_SIZE = $clog2(REC_WIDTH*REC_HEIGHT)+CAM_D_SIZE, ROI_X0 = (IMG_WIDTH-CNN_INPUT_WIDTH*REC_WIDTH)/2, ROI_Y0 likewise for height.
REQ-012 SHALL have port clk  input  1  sole clock, rising edge.
REQ-013 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-014 SHALL have port start  input  1  single-cycle arm request.
REQ-015 SHALL have port mode  input  2  00 average, 01 max, 10 binary-threshold, 11 treated as 00.
REQ-016 SHALL have ports pix_valid input 1, pix_sof input 1 (first pixel of frame), pix_data input CAM_D_SIZE.
REQ-017 SHALL have ports out_we output 1, out_addr output $clog2(OUT_W*OUT_H), out_data output CAM_D_SIZE.
REQ-018 SHALL have ports busy output 1 and frame_ready output 1 (one-cycle pulse).

Function
REQ-019 States: IDLE, WAIT_SOF, ACCUM, PAD, DONE; busy high in all but IDLE.
REQ-020 IDLE: start -> WAIT_SOF; mode registered at that edge and held for the frame; start ignored in all other states.
REQ-021 WAIT_SOF: pix_valid&pix_sof -> ACCUM, that pixel is x=0,y=0; other pixels ignored.
REQ-022 ACCUM: x,y advance per valid pixel, x wraps at IMG_WIDTH with y+1; invalid cycles hold counters.
REQ-023 Pixel inside ROI (x-ROI_X0 < CNN_INPUT_WIDTH*REC_WIDTH, y likewise) updates accumulator acc[bx], bx=(x-ROI_X0)/REC_WIDTH; one ACC_D_SIZE-bit accumulator per cell column.
REQ-024 First pixel of a block loads acc (pixel, not add); average/binary modes add, max mode keeps larger value.
REQ-025 Last pixel of a block (local x=REC_WIDTH-1, local y=REC_HEIGHT-1) causes, next cycle, out_we=1, out_addr=(by+CNN_INPUT_PAD)*OUT_W+bx+CNN_INPUT_PAD.
REQ-026 out_data: average = sum>>$clog2(REC_WIDTH*REC_HEIGHT); max = running max; binary = all ones if sum>=THRESHOLD else 0.
REQ-027 After the write of last ROI cell -> PAD; remaining frame pixels ignored.
REQ-028 PAD: scan addresses 0..OUT_W*OUT_H-1, one per cycle, out_we=1 with out_data=PAD_VALUE only for border addresses, out_we=0 for interior.
REQ-029 After final PAD address -> DONE; DONE pulses frame_ready one cycle, returns to IDLE.
REQ-030 pix_sof asserted with pix_valid during ACCUM restarts the frame at x=0,y=0, discards partial blocks, no writes for aborted blocks.
REQ-031 out_we SHALL be low in IDLE, WAIT_SOF, DONE; never two writes to one interior address per frame.

Reset
REQ-032 rst_n low asynchronously forces IDLE, out_we=0, out_addr=0, out_data=0, busy=0, frame_ready=0, counters and accumulators 0, including mid-frame.
REQ-033 After rst_n release, no output activity until start.

Verification
REQ-034 Mode 00, frame of constant 0x40 -> 784 interior writes of 0x40, 240 border writes of 0x00, one frame_ready pulse, busy low after.
REQ-035 Mode 01, 0x10 everywhere except 0xFF at (208,128) -> address 66 gets 0xFF, all other interior 0x10.
REQ-036 Mode 10, block of 0x60 -> 0xFF (sum 6144 = THRESHOLD); block of 0x5F -> 0x00.
REQ-037 pix_sof reissued at y=200 -> counting restarts, first write occurs at new y=135 relative to second SOF, final counts as REQ-034.
REQ-038 rst_n low at y=300 -> outputs zero immediately; start pulse while busy -> ignored, mode change mid-frame -> no effect.

Source files
------------

// File: rtl/cnn_input_pooler.sv
`default_nettype none
// cnn_input_pooler: reduces a centred camera ROI to CNN input cells (average, max or
// binary threshold) and frames the pooled image with a constant border.
module cnn_input_pooler #(
    parameter int IMG_WIDTH        = 640,
    parameter int IMG_HEIGHT       = 480,
    parameter int REC_WIDTH        = 8,
    parameter int REC_HEIGHT       = 8,
    parameter int CNN_INPUT_WIDTH  = 28,
    parameter int CNN_INPUT_HEIGHT = 28,
    parameter int CNN_INPUT_PAD    = 2,
    parameter int CAM_D_SIZE       = 8,
    parameter int THRESHOLD        = 'b01100000000000,
    parameter int PAD_VALUE        = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  pix_valid,
    input  logic                  pix_sof,
    input  logic [CAM_D_SIZE-1:0] pix_data,
    output logic                  out_we,
    output logic [$clog2((CNN_INPUT_WIDTH+2*CNN_INPUT_PAD)*(CNN_INPUT_HEIGHT+2*CNN_INPUT_PAD))-1:0] out_addr,
    output logic [CAM_D_SIZE-1:0] out_data,
    output logic                  busy,
    output logic                  frame_ready
);
    localparam int OUT_W      = CNN_INPUT_WIDTH + 2*CNN_INPUT_PAD;
    localparam int OUT_H      = CNN_INPUT_HEIGHT + 2*CNN_INPUT_PAD;
    localparam int ADDR_W     = $clog2(OUT_W*OUT_H);
    localparam int LOG_N      = $clog2(REC_WIDTH*REC_HEIGHT);
    localparam int ACC_D_SIZE = LOG_N + CAM_D_SIZE;
    localparam int ROI_W      = CNN_INPUT_WIDTH*REC_WIDTH;
    localparam int ROI_H      = CNN_INPUT_HEIGHT*REC_HEIGHT;
    localparam int ROI_X0     = (IMG_WIDTH-ROI_W)/2;
    localparam int ROI_Y0     = (IMG_HEIGHT-ROI_H)/2;
    localparam int X_W        = $clog2(IMG_WIDTH+1);
    localparam int Y_W        = $clog2(IMG_HEIGHT+1);
    localparam int LX_W       = $clog2(REC_WIDTH);
    localparam int LY_W       = $clog2(REC_HEIGHT);
    localparam int BX_W       = X_W - LX_W;
    localparam int BY_W       = Y_W - LY_W;
    localparam int CI_W       = (CNN_INPUT_WIDTH > 1) ? $clog2(CNN_INPUT_WIDTH) : 1;
    localparam int ROW_W      = $clog2(OUT_H+1);
    localparam int COL_W      = $clog2(OUT_W+1);

    typedef enum logic [2:0] {IDLE, WAIT_SOF, ACCUM, PAD, DONE} state_t;

    state_t state, next_state;
    logic [1:0]            mode_q;
    logic [X_W-1:0]        x;
    logic [Y_W-1:0]        y;
    logic [ACC_D_SIZE-1:0] acc [CNN_INPUT_WIDTH];
    logic [ROW_W-1:0]      pad_row;
    logic [COL_W-1:0]      pad_col;
    logic [ADDR_W-1:0]     pad_addr;

    logic                  take, in_roi, block_first, block_last, last_cell;
    logic                  pad_end, pad_border;
    logic [X_W-1:0]        px, dx;
    logic [Y_W-1:0]        py, dy;
    logic [BX_W-1:0]       bx;
    logic [BY_W-1:0]       by;
    logic [CI_W-1:0]       col_idx;
    logic [ACC_D_SIZE-1:0] pix_ext, acc_cur, acc_new;
    logic [CAM_D_SIZE-1:0] cell_value;
    logic [ADDR_W-1:0]     cell_addr;

    // A SOF pixel is position (0,0) whether it opens the frame or restarts it.
    assign take    = pix_valid && ((state == ACCUM) || ((state == WAIT_SOF) && pix_sof));
    assign px      = pix_sof ? '0 : x;
    assign py      = pix_sof ? '0 : y;
    // Unsigned wrap makes coordinates left of / above the ROI fail the range test.
    assign dx      = px - X_W'(ROI_X0);
    assign dy      = py - Y_W'(ROI_Y0);
    assign in_roi  = (dx < X_W'(ROI_W)) && (dy < Y_W'(ROI_H));
    assign bx      = dx[X_W-1:LX_W];
    assign by      = dy[Y_W-1:LY_W];
    assign col_idx = bx[CI_W-1:0];
    assign block_first = (dx[LX_W-1:0] == '0) && (dy[LY_W-1:0] == '0);
    assign block_last  = (dx[LX_W-1:0] == '1) && (dy[LY_W-1:0] == '1);
    assign last_cell   = block_last && (bx == BX_W'(CNN_INPUT_WIDTH-1))
                                    && (by == BY_W'(CNN_INPUT_HEIGHT-1));
    assign pix_ext   = ACC_D_SIZE'(pix_data);
    assign cell_addr = ADDR_W'((32'(by) + 32'(CNN_INPUT_PAD)) * 32'(OUT_W)
                               + 32'(bx) + 32'(CNN_INPUT_PAD));

    always_comb begin
        acc_cur = acc[col_idx];
        acc_new = acc_cur + pix_ext;
        if (block_first)
            acc_new = pix_ext;
        else if (mode_q == 2'b01)
            acc_new = (pix_ext > acc_cur) ? pix_ext : acc_cur;
    end

    always_comb begin
        case (mode_q)
            2'b01:   cell_value = acc_new[CAM_D_SIZE-1:0];
            2'b10:   cell_value = (acc_new >= ACC_D_SIZE'(THRESHOLD)) ? '1 : '0;
            default: cell_value = acc_new[LOG_N +: CAM_D_SIZE];
        endcase
    end

    assign pad_end    = (pad_row == ROW_W'(OUT_H));
    assign pad_border = (pad_row <  ROW_W'(CNN_INPUT_PAD))
                     || (pad_row >= ROW_W'(CNN_INPUT_PAD+CNN_INPUT_HEIGHT))
                     || (pad_col <  COL_W'(CNN_INPUT_PAD))
                     || (pad_col >= COL_W'(CNN_INPUT_PAD+CNN_INPUT_WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = WAIT_SOF;
            WAIT_SOF: if (pix_valid && pix_sof) next_state = ACCUM;
            ACCUM:    if (take && in_roi && last_cell) next_state = PAD;
            PAD:      if (pad_end) next_state = DONE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= '0;
            x        <= '0;
            y        <= '0;
            pad_row  <= '0;
            pad_col  <= '0;
            pad_addr <= '0;
            out_we   <= 1'b0;
            out_addr <= '0;
            out_data <= '0;
            for (int i = 0; i < CNN_INPUT_WIDTH; i++) acc[i] <= '0;
        end else begin
            out_we <= 1'b0;
            if (state == IDLE) begin
                pad_row  <= '0;
                pad_col  <= '0;
                pad_addr <= '0;
                if (start) begin
                    mode_q <= mode;
                    x      <= '0;
                    y      <= '0;
                end
            end
            if (take) begin
                if (px == X_W'(IMG_WIDTH-1)) begin
                    x <= '0;
                    y <= py + 1'b1;
                end else begin
                    x <= px + 1'b1;
                    y <= py;
                end
                if (in_roi) begin
                    acc[col_idx] <= acc_new;
                    if (block_last) begin
                        out_we   <= 1'b1;
                        out_addr <= cell_addr;
                        out_data <= cell_value;
                    end
                end
            end
            // Border scan: interior addresses are visited but never written.
            if ((state == PAD) && !pad_end) begin
                out_we   <= pad_border;
                out_addr <= pad_addr;
                out_data <= CAM_D_SIZE'(PAD_VALUE);
                pad_addr <= pad_addr + 1'b1;
                if (pad_col == COL_W'(OUT_W-1)) begin
                    pad_col <= '0;
                    pad_row <= pad_row + 1'b1;
                end else begin
                    pad_col <= pad_col + 1'b1;
                end
            end
        end
    end

    assign busy        = (state != IDLE);
    assign frame_ready = (state == DONE);

endmodule
`default_nettype wire
